axi_lite_rd_arbiter: RTL and testbench

Two-master to one-slave arbiter for the AXI-lite read channel (AR/R) of the shared RAM port. IFU instruction fetch and LSU loads both need the single read port of ram_axi_lite; this block grants it to one master per transaction and routes the response back. The write channels (AW/W/B) do not pass through this block: they run LSU-to-RAM directly.

---
 rtl/axi_lite_rd_arbiter.sv | 147 ++++++++++++++
 tb/tb_axi_lite_rd_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_rd_arbiter.sv
// Two-master (IFU, LSU) to one-slave arbiter for the AXI-lite read channel.
// One outstanding transaction; the response is routed back to the granted owner.
module axi_lite_rd_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter bit RR_MODE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_arvalid,
    input  logic [ADDR_W-1:0] ifu_araddr,
    output logic              ifu_arready,
    output logic              ifu_rvalid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic [1:0]        ifu_rresp,
    input  logic              ifu_rready,
    input  logic              lsu_arvalid,
    input  logic [ADDR_W-1:0] lsu_araddr,
    output logic              lsu_arready,
    output logic              lsu_rvalid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic [1:0]        lsu_rresp,
    input  logic              lsu_rready,
    output logic              s_arvalid,
    output logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arready,
    input  logic              s_rvalid,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    output logic              s_rready,
    output logic              arb_busy,
    output logic              arb_owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rr_last_q, rr_last_d;
    logic              pick_lsu;
    logic              owner_rready;

    assign owner_rready = owner_q ? lsu_rready : ifu_rready;

    // Winner on a tie: LSU in fixed mode, otherwise whoever was not served last.
    always_comb begin
        pick_lsu = lsu_arvalid;
        if (ifu_arvalid && lsu_arvalid) begin
            pick_lsu = RR_MODE ? !rr_last_q : 1'b1;
        end
    end

    // State register: FSM state, owner, latched address, last-served master.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            addr_q    <= '0;
            rr_last_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            rr_last_q <= rr_last_d;
        end
    end

    // Next state: grant in IDLE, wait for address handshake, then data handshake.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        rr_last_d = rr_last_q;
        unique case (state_q)
            IDLE: begin
                if (ifu_arvalid || lsu_arvalid) begin
                    owner_d = pick_lsu;
                    addr_d  = pick_lsu ? lsu_araddr : ifu_araddr;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (s_arready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (s_rvalid && owner_rready) begin
                    rr_last_d = owner_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: steer slave handshakes to the owner only; all zero while in reset.
    always_comb begin
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = 2'b00;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = 2'b00;
        s_arvalid   = 1'b0;
        s_araddr    = '0;
        s_rready    = 1'b0;
        arb_busy    = 1'b0;
        arb_owner   = 1'b0;
        if (!rst) begin
            arb_busy  = (state_q != IDLE);
            arb_owner = owner_q;
            unique case (state_q)
                ADDR: begin
                    s_arvalid = 1'b1;
                    s_araddr  = addr_q;
                    if (owner_q) begin
                        lsu_arready = s_arready;
                    end else begin
                        ifu_arready = s_arready;
                    end
                end
                RESP: begin
                    s_rready = owner_rready;
                    if (owner_q) begin
                        lsu_rvalid = s_rvalid;
                        lsu_rdata  = s_rdata;
                        lsu_rresp  = s_rresp;
                    end else begin
                        ifu_rvalid = s_rvalid;
                        ifu_rdata  = s_rdata;
                        ifu_rresp  = s_rresp;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Directed self-checking bench: instance 0 runs round-robin, instance 1 fixed
// priority; each instance has its own master and slave stimulus.
module tb_axi_lite_rd_arbiter;

    logic clk;
    logic rst;

    logic [1:0]  ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready;
    logic [1:0]  s_arready, s_rvalid;
    logic [63:0] ifu_araddr [2];
    logic [63:0] lsu_araddr [2];
    logic [63:0] s_rdata [2];
    logic [1:0]  s_rresp [2];

    wire [1:0]  ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid;
    wire [1:0]  s_arvalid, s_rready, arb_busy, arb_owner;
    wire [63:0] ifu_rdata [2];
    wire [63:0] lsu_rdata [2];
    wire [63:0] s_araddr [2];
    wire [1:0]  ifu_rresp [2];
    wire [1:0]  lsu_rresp [2];

    int total = 0;
    int bad   = 0;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        axi_lite_rd_arbiter #(
            .ADDR_W(64),
            .DATA_W(64),
            .RR_MODE(k == 0)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .ifu_arvalid(ifu_arvalid[k]),
            .ifu_araddr(ifu_araddr[k]),
            .ifu_arready(ifu_arready[k]),
            .ifu_rvalid(ifu_rvalid[k]),
            .ifu_rdata(ifu_rdata[k]),
            .ifu_rresp(ifu_rresp[k]),
            .ifu_rready(ifu_rready[k]),
            .lsu_arvalid(lsu_arvalid[k]),
            .lsu_araddr(lsu_araddr[k]),
            .lsu_arready(lsu_arready[k]),
            .lsu_rvalid(lsu_rvalid[k]),
            .lsu_rdata(lsu_rdata[k]),
            .lsu_rresp(lsu_rresp[k]),
            .lsu_rready(lsu_rready[k]),
            .s_arvalid(s_arvalid[k]),
            .s_araddr(s_araddr[k]),
            .s_arready(s_arready[k]),
            .s_rvalid(s_rvalid[k]),
            .s_rdata(s_rdata[k]),
            .s_rresp(s_rresp[k]),
            .s_rready(s_rready[k]),
            .arb_busy(arb_busy[k]),
            .arb_owner(arb_owner[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait slave transaction starting in IDLE; requests set by caller.
    task automatic xact(int k, logic own, logic [63:0] a, logic [63:0] d);
        s_arready[k]  = 1'b1;
        s_rvalid[k]   = 1'b1;
        s_rdata[k]    = d;
        s_rresp[k]    = d[1:0];
        ifu_rready[k] = 1'b1;
        lsu_rready[k] = 1'b1;
        #1;
        chk("idle_busy", arb_busy[k], 0);
        chk("idle_ifu_rvalid", ifu_rvalid[k], 0);
        chk("idle_lsu_rvalid", lsu_rvalid[k], 0);
        chk("idle_s_rready", s_rready[k], 0);
        chk("idle_s_arvalid", s_arvalid[k], 0);
        cyc();
        chk("addr_busy", arb_busy[k], 1);
        chk("addr_owner", arb_owner[k], own);
        chk("addr_s_arvalid", s_arvalid[k], 1);
        chk("addr_s_araddr", s_araddr[k], a);
        chk("addr_ifu_arready", ifu_arready[k], !own);
        chk("addr_lsu_arready", lsu_arready[k], own);
        chk("addr_ifu_rvalid", ifu_rvalid[k], 0);
        chk("addr_lsu_rvalid", lsu_rvalid[k], 0);
        cyc();
        chk("resp_busy", arb_busy[k], 1);
        chk("resp_s_rready", s_rready[k], 1);
        chk("resp_s_arvalid", s_arvalid[k], 0);
        chk("resp_ifu_rvalid", ifu_rvalid[k], !own);
        chk("resp_lsu_rvalid", lsu_rvalid[k], own);
        chk("resp_ifu_rdata", ifu_rdata[k], own ? 64'd0 : d);
        chk("resp_lsu_rdata", lsu_rdata[k], own ? d : 64'd0);
        chk("resp_ifu_rresp", ifu_rresp[k], own ? 64'd0 : {62'd0, d[1:0]});
        chk("resp_lsu_rresp", lsu_rresp[k], own ? {62'd0, d[1:0]} : 64'd0);
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        ifu_arvalid = '0;
        lsu_arvalid = '0;
        ifu_rready  = '0;
        lsu_rready  = '0;
        s_arready   = '0;
        s_rvalid    = '0;
        for (int i = 0; i < 2; i++) begin
            ifu_araddr[i] = '0;
            lsu_araddr[i] = '0;
            s_rdata[i]    = '0;
            s_rresp[i]    = '0;
        end

        // reset with both masters requesting
        ifu_arvalid[0] = 1'b1;
        lsu_arvalid[0] = 1'b1;
        ifu_araddr[0]  = 64'h1000;
        lsu_araddr[0]  = 64'h2000;
        s_arready[0]   = 1'b1;
        s_rvalid[0]    = 1'b1;
        ifu_rready[0]  = 1'b1;
        lsu_rready[0]  = 1'b1;
        cyc();
        cyc();
        chk("rst_s_arvalid", s_arvalid[0], 0);
        chk("rst_s_araddr", s_araddr[0], 0);
        chk("rst_busy", arb_busy[0], 0);
        chk("rst_owner", arb_owner[0], 0);
        chk("rst_ifu_arready", ifu_arready[0], 0);
        chk("rst_lsu_arready", lsu_arready[0], 0);
        chk("rst_ifu_rvalid", ifu_rvalid[0], 0);
        chk("rst_lsu_rvalid", lsu_rvalid[0], 0);
        chk("rst_s_rready", s_rready[0], 0);
        rst = 1'b0;

        // round-robin alternation, IFU first
        xact(0, 1'b0, 64'h1000, 64'hA0A0_0000_1111_0001);
        xact(0, 1'b1, 64'h2000, 64'hB0B0_0000_2222_0002);
        xact(0, 1'b0, 64'h1000, 64'hC0C0_0000_3333_0003);
        xact(0, 1'b1, 64'h2000, 64'hD0D0_0000_4444_0000);

        // IFU-only fetch
        lsu_arvalid[0] = 1'b0;
        ifu_araddr[0]  = 64'h8000_0000;
        xact(0, 1'b0, 64'h8000_0000, 64'h0000_0013_0000_0093);
        ifu_arvalid[0] = 1'b0;

        // fixed priority: LSU wins while it requests
        ifu_arvalid[1] = 1'b1;
        lsu_arvalid[1] = 1'b1;
        ifu_araddr[1]  = 64'h3000;
        lsu_araddr[1]  = 64'h4000;
        xact(1, 1'b1, 64'h4000, 64'h1111_2222_3333_4441);
        xact(1, 1'b1, 64'h4000, 64'h5555_6666_7777_8882);
        lsu_arvalid[1] = 1'b0;
        xact(1, 1'b0, 64'h3000, 64'h9999_AAAA_BBBB_CCC3);
        ifu_arvalid[1] = 1'b0;

        // slave wait states on AR and R; LSU drops arvalid after grant
        s_arready[0]   = 1'b0;
        s_rvalid[0]    = 1'b0;
        lsu_rready[0]  = 1'b0;
        lsu_arvalid[0] = 1'b1;
        lsu_araddr[0]  = 64'h5000;
        #1;
        chk("ws_idle_busy", arb_busy[0], 0);
        cyc();
        lsu_arvalid[0] = 1'b0;
        lsu_araddr[0]  = 64'hDEAD;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ws_ar_s_arvalid", s_arvalid[0], 1);
            chk("ws_ar_s_araddr", s_araddr[0], 64'h5000);
            chk("ws_ar_lsu_arready", lsu_arready[0], 0);
            chk("ws_ar_busy", arb_busy[0], 1);
            cyc();
        end
        s_arready[0] = 1'b1;
        #1;
        chk("ws_ar_handshake", lsu_arready[0], 1);
        chk("ws_ar_ifu_arready", ifu_arready[0], 0);
        cyc();
        s_arready[0] = 1'b0;
        s_rvalid[0]  = 1'b1;
        s_rdata[0]   = 64'h0123_4567_89AB_CDEF;
        s_rresp[0]   = 2'b10;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("ws_r_s_rready", s_rready[0], 0);
            chk("ws_r_lsu_rvalid", lsu_rvalid[0], 1);
            chk("ws_r_lsu_rdata", lsu_rdata[0], 64'h0123_4567_89AB_CDEF);
            chk("ws_r_lsu_rresp", lsu_rresp[0], 2'b10);
            chk("ws_r_busy", arb_busy[0], 1);
            cyc();
        end
        lsu_rready[0] = 1'b1;
        #1;
        chk("ws_r_handshake", s_rready[0], 1);
        cyc();
        chk("ws_done_busy", arb_busy[0], 0);
        chk("ws_owner_held", arb_owner[0], 1);
        chk("ws_stray_rvalid", lsu_rvalid[0], 0);
        chk("ws_stray_s_rready", s_rready[0], 0);
        s_rvalid[0] = 1'b0;

        // reset while in RESP drops the transaction
        s_arready[0]   = 1'b1;
        lsu_rready[0]  = 1'b0;
        lsu_arvalid[0] = 1'b1;
        lsu_araddr[0]  = 64'h6000;
        cyc();
        lsu_arvalid[0] = 1'b0;
        cyc();
        s_rvalid[0] = 1'b1;
        #1;
        chk("mr_resp_busy", arb_busy[0], 1);
        chk("mr_resp_rvalid", lsu_rvalid[0], 1);
        chk("mr_resp_owner", arb_owner[0], 1);
        rst = 1'b1;
        #1;
        chk("mr_rst_rvalid", lsu_rvalid[0], 0);
        chk("mr_rst_busy", arb_busy[0], 0);
        cyc();
        rst = 1'b0;
        #1;
        chk("mr_after_busy", arb_busy[0], 0);
        chk("mr_after_s_rready", s_rready[0], 0);
        chk("mr_after_lsu_rvalid", lsu_rvalid[0], 0);
        chk("mr_after_ifu_rvalid", ifu_rvalid[0], 0);
        chk("mr_after_owner", arb_owner[0], 0);
        cyc();
        chk("mr_idle_busy", arb_busy[0], 0);
        chk("mr_idle_lsu_rvalid", lsu_rvalid[0], 0);
        chk("mr_idle_s_arvalid", s_arvalid[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
